// File: rtl/usb_tx_word_packer.sv
// Packs an 8-bit byte stream into 32-bit little-endian words with byte enables and
// buffers them in a first-word-fall-through FIFO for the FX3 stream-in writer.
module usb_tx_word_packer #(
    parameter int ADDR_W        = 4,
    parameter int FLUSH_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    output logic [31:0]       out_word,
    output logic [3:0]        out_be,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   level,
    output logic              overrun,
    input  logic              clr_overrun
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam int ENTRY_W = 37;
    localparam int CNT_W   = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(FLUSH_TIMEOUT);
    localparam bit   TIMEOUT_EN  = (FLUSH_TIMEOUT != 0);

    // Packer state
    logic [1:0]        lane_reg, lane_next;
    logic [31:0]       pack_reg, pack_next;
    logic [3:0]        be_reg, be_next;
    logic [CNT_W-1:0]  idle_cnt_reg, idle_cnt_next;

    // FIFO state
    logic [ADDR_W:0]   wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W:0]   rd_ptr_reg, rd_ptr_next;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic              overrun_reg, overrun_next;

    logic              fifo_full;
    logic              fifo_empty;
    logic              flush_pending;
    logic              accept;
    logic              word_done;
    logic              flush_push;
    logic              push;
    logic              pop;
    logic [31:0]       merged_pack;
    logic [3:0]        merged_be;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;

    assign fifo_full  = (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]) &&
                        (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]);
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);

    assign flush_pending = TIMEOUT_EN && (lane_reg != 2'd0) && (idle_cnt_reg == TIMEOUT_CNT);

    // Ready is withheld whenever the FIFO is full, even for bytes that would only
    // land in the pack register, so a completing byte can never find the FIFO full.
    assign in_ready = !fifo_full && !flush_pending;
    assign accept   = in_valid && in_ready;

    // Pack register with the incoming byte merged into its lane
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic lane_hit;
            assign lane_hit = accept && (lane_reg == 2'(gi));
            assign merged_pack[8*gi +: 8] = lane_hit ? in_byte : pack_reg[8*gi +: 8];
            assign merged_be[gi]          = be_reg[gi] | lane_hit;
        end
    endgenerate

    assign word_done  = accept && ((lane_reg == 2'd3) || in_last);
    assign flush_push = flush_pending && !fifo_full;
    assign push       = word_done || flush_push;
    assign pop        = !fifo_empty && out_ready;

    // On a timeout flush no byte is accepted, so the merged values equal the registers.
    assign push_entry = {word_done ? in_last : 1'b0, merged_be, merged_pack};

    always_comb begin
        lane_next     = lane_reg;
        pack_next     = pack_reg;
        be_next       = be_reg;
        idle_cnt_next = idle_cnt_reg;
        if (push) begin
            lane_next     = 2'd0;
            pack_next     = 32'd0;
            be_next       = 4'd0;
            idle_cnt_next = '0;
        end else if (accept) begin
            lane_next     = lane_reg + 2'd1;
            pack_next     = merged_pack;
            be_next       = merged_be;
            idle_cnt_next = '0;
        end else if ((lane_reg != 2'd0) && (idle_cnt_reg != TIMEOUT_CNT)) begin
            idle_cnt_next = idle_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
    end

    // A new overrun event in the same cycle as a clear keeps the flag set
    always_comb begin
        overrun_next = overrun_reg;
        if (in_valid && !in_ready) begin
            overrun_next = 1'b1;
        end else if (clr_overrun) begin
            overrun_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_reg     <= 2'd0;
            pack_reg     <= 32'd0;
            be_reg       <= 4'd0;
            idle_cnt_reg <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overrun_reg  <= 1'b0;
        end else begin
            lane_reg     <= lane_next;
            pack_reg     <= pack_next;
            be_reg       <= be_next;
            idle_cnt_reg <= idle_cnt_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            overrun_reg  <= overrun_next;
        end
    end

    // Storage carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[ADDR_W-1:0]] <= push_entry;
        end
    end

    // Fall-through read: the head entry is visible as soon as it is written
    assign head_entry = mem[rd_ptr_reg[ADDR_W-1:0]];

    assign out_valid = !fifo_empty;
    assign out_word  = fifo_empty ? 32'd0 : head_entry[31:0];
    assign out_be    = fifo_empty ? 4'd0  : head_entry[35:32];
    assign out_last  = fifo_empty ? 1'b0  : head_entry[36];
    assign level     = wr_ptr_reg - rd_ptr_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_usb_tx_word_packer.sv
// Self-checking bench for usb_tx_word_packer: directed table, hand sequences for
// timeout/full/reset corners, and randomized traffic against a queue-based model.
module tb_usb_tx_word_packer;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int T      = 255;

    logic              clk;
    logic              rst_n;
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [31:0]       out_word;
    logic [3:0]        out_be;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W:0]   level;
    logic              overrun;
    logic              clr_overrun;

    int errors = 0;
    int checks = 0;

    usb_tx_word_packer #(.ADDR_W(ADDR_W), .FLUSH_TIMEOUT(T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_last     (in_last),
        .out_word    (out_word),
        .out_be      (out_be),
        .out_last    (out_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .level       (level),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of stored words and a queue of bytes in the partial word
    typedef struct packed {
        logic [31:0] word;
        logic [3:0]  be;
        logic        last;
    } entry_t;

    entry_t m_fifo[$];
    byte unsigned m_part[$];
    int m_idle;
    bit m_ovr;

    typedef struct {
        bit          v;
        logic [7:0]  b;
        bit          l;
        bit          ordy;
        bit          e_valid;
        logic [31:0] e_word;
        logic [3:0]  e_be;
        bit          e_last;
        int          e_level;
    } vec_t;

    vec_t tbl[8];

    function automatic entry_t make_entry(bit last);
        entry_t e;
        e.word = 32'd0;
        e.be   = 4'd0;
        for (int k = 0; k < m_part.size(); k++) begin
            e.word = e.word | (32'(m_part[k]) << (8 * k));
            e.be[k] = 1'b1;
        end
        e.last = last;
        return e;
    endfunction

    function automatic bit model_flush();
        return (T != 0) && (m_part.size() > 0) && (m_idle >= T);
    endfunction

    function automatic bit model_ready();
        return (m_fifo.size() < DEPTH) && !model_flush();
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_part.delete();
        m_idle = 0;
        m_ovr  = 1'b0;
    endtask

    task automatic check_val(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(string name);
        bit          ev;
        bit          bad;
        entry_t      eh;
        ev  = (m_fifo.size() > 0);
        eh  = ev ? m_fifo[0] : '0;
        bad = (out_valid !== ev) || (level !== 5'(m_fifo.size())) ||
              (in_ready !== model_ready()) || (overrun !== m_ovr);
        if (ev && ((out_word !== eh.word) || (out_be !== eh.be) || (out_last !== eh.last)))
            bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s: got v=%0b w=%h be=%b l=%0b lvl=%0d rdy=%0b ovr=%0b expected v=%0b w=%h be=%b l=%0b lvl=%0d rdy=%0b ovr=%0b",
                     name, out_valid, out_word, out_be, out_last, level, in_ready, overrun,
                     ev, eh.word, eh.be, eh.last, m_fifo.size(), model_ready(), m_ovr);
        end
    endtask

    // One clock: drive inputs after the falling edge, update the model, check at the next falling edge
    task automatic cycle(bit v, logic [7:0] b, bit l, bit ordy, bit clr);
        bit rdy;
        bit fl;
        int sz;
        in_valid    = v;
        in_byte     = b;
        in_last     = l;
        out_ready   = ordy;
        clr_overrun = clr;
        rdy = model_ready();
        fl  = model_flush();
        sz  = m_fifo.size();
        m_ovr = (v && !rdy) ? 1'b1 : (clr ? 1'b0 : m_ovr);
        if (sz > 0 && ordy) void'(m_fifo.pop_front());
        if (v && rdy) begin
            m_part.push_back(b);
            m_idle = 0;
            if (m_part.size() == 4 || l) begin
                m_fifo.push_back(make_entry(l));
                m_part.delete();
            end
        end else if (fl && sz < DEPTH) begin
            m_fifo.push_back(make_entry(1'b0));
            m_part.delete();
            m_idle = 0;
        end else if (m_part.size() > 0) begin
            m_idle++;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs("cycle");
    endtask

    task automatic check_reset_outputs(string name);
        check_val({name, "_valid"}, 64'(out_valid), 64'd0);
        check_val({name, "_word"},  64'(out_word),  64'd0);
        check_val({name, "_be_last_lvl"}, 64'({out_be, out_last, level}), 64'd0);
        check_val({name, "_rdy_ovr"}, 64'({in_ready, overrun}), 64'b10);
    endtask

    task automatic reset_now(string name);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(name);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; in_byte = 8'd0; in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b0; clr_overrun = 1'b0;
        model_reset();

        tbl[0] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 0};
        tbl[1] = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 0};
        tbl[2] = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 0};
        tbl[3] = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 32'h04030201, 4'hF, 1'b0, 1};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 0};
        tbl[5] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 0};
        tbl[6] = '{1'b1, 8'hBB, 1'b1, 1'b0, 1'b1, 32'h0000BBAA, 4'h3, 1'b1, 1};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 0};

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs("after_reset");

        // Full word and short frame from the vector table
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].v, tbl[i].b, tbl[i].l, tbl[i].ordy, 1'b0);
            checks++;
            if ((out_valid !== tbl[i].e_valid) || (level !== 5'(tbl[i].e_level)) ||
                (tbl[i].e_valid && ((out_word !== tbl[i].e_word) || (out_be !== tbl[i].e_be) ||
                                    (out_last !== tbl[i].e_last)))) begin
                errors++;
                $display("FAIL table[%0d]: got v=%0b w=%h be=%b l=%0b lvl=%0d expected v=%0b w=%h be=%b l=%0b lvl=%0d",
                         i, out_valid, out_word, out_be, out_last, level,
                         tbl[i].e_valid, tbl[i].e_word, tbl[i].e_be, tbl[i].e_last, tbl[i].e_level);
            end
        end

        // Idle timeout flush of a one-byte partial word
        cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 254; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check_val("no_push_254", 64'(out_valid), 64'd0);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            found = out_valid;
        end
        check_val("timeout_valid", 64'(out_valid), 64'd1);
        check_val("timeout_word", 64'({out_word, out_be, out_last}), 64'({32'h55, 4'b0001, 1'b0}));
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Fill to full, provoke overrun, then drain in order
        for (int i = 0; i < 64; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        check_val("full_level", 64'(level), 64'd16);
        check_val("full_ready", 64'(in_ready), 64'd0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        check_val("overrun_set", 64'(overrun), 64'd1);
        for (int i = 0; i < 16; i++) begin
            check_val("drain_word", 64'(out_word),
                      64'({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}));
            cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end
        check_val("drained_level", 64'(level), 64'd0);
        check_val("drained_ready", 64'(in_ready), 64'd1);

        // Simultaneous push and pop at level 8, then overrun clear
        for (int i = 0; i < 35; i++) cycle(1'b1, 8'(100 + i), 1'b0, 1'b0, 1'b0);
        check_val("level8", 64'(level), 64'd8);
        cycle(1'b1, 8'd135, 1'b0, 1'b1, 1'b0);
        check_val("pushpop_level", 64'(level), 64'd8);
        check_val("pushpop_head", 64'(out_word), 64'h6B6A6968);
        check_val("overrun_kept", 64'(overrun), 64'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check_val("overrun_clr", 64'(overrun), 64'd0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check_val("pushpop_empty", 64'(out_valid), 64'd0);

        // Reset mid-word, then the first new byte must land in lane 0
        cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h78, 1'b0, 1'b0, 1'b0);
        reset_now("rst_midword");
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0, 1'b0);
        check_val("post_reset_word", 64'({out_word, out_be}), 64'({32'h44332211, 4'hF}));

        // Reset mid-drain
        for (int i = 0; i < 12; i++) cycle(1'b1, 8'(i + 200), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        reset_now("rst_middrain");
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            cycle(($urandom_range(0, 99) < 70), 8'($urandom), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 60 : 25)),
                  ($urandom_range(0, 19) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
